skew_mes_sched: RTL and testbench



---
 rtl/skew_mes_sched.sv | 273 +++++++++++++++++++++++++++
 tb/tb_skew_mes_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_mes_sched.sv
// Multi-channel scheduler sharing one skew measurement controller across CH_NUM channels.
// Optional averaging of 2^AVG_LOG2 runs per channel is built when SKEW_MES_SCHED_AVG_EN is defined.
module skew_mes_sched #(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned CODE_W     = 10,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned TMO_W      = 16,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [CH_NUM-1:0]         ch_mask_i,
    input  logic [TMO_W-1:0]          tmo_cyc_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [$clog2(CH_NUM)-1:0] ch_sel_o,
    output logic                      mes_run_o,
    input  logic                      mes_rdy_i,
    input  logic                      mes_err_i,
    input  logic [CODE_W-1:0]         mes_code_i,
    output logic [CH_NUM*CODE_W-1:0]  res_code_o,
    output logic [CH_NUM-1:0]         res_err_o,
    output logic [CH_NUM-1:0]         res_tmo_o,
    output logic [CH_NUM-1:0]         res_valid_o
);

    localparam int unsigned SelW = $clog2(CH_NUM);
    localparam int unsigned PtrW = $clog2(CH_NUM + 1);
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
`ifdef SKEW_MES_SCHED_AVG_EN
    localparam int unsigned AccW    = CODE_W + AVG_LOG2;
    localparam int unsigned RepW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned RepLast = (1 << AVG_LOG2) - 1;
`else
    localparam int unsigned AccW = CODE_W;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StRun,
        StStore,
        StRelease,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [CH_NUM-1:0]        mask_q, mask_d;
    logic [SelW-1:0]          sel_q, sel_d;
    logic [SetW-1:0]          set_cnt_q, set_cnt_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [AccW-1:0]          acc_q, acc_d;
    logic                     cur_err_q, cur_err_d;
    logic                     cur_tmo_q, cur_tmo_d;
    logic                     again_q, again_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     run_q, run_d;
    logic [CH_NUM*CODE_W-1:0] res_code_q, res_code_d;
    logic [CH_NUM-1:0]        res_err_q, res_err_d;
    logic [CH_NUM-1:0]        res_tmo_q, res_tmo_d;
    logic [CH_NUM-1:0]        res_valid_q, res_valid_d;
`ifdef SKEW_MES_SCHED_AVG_EN
    logic [RepW-1:0]          rep_q, rep_d;
`endif

    logic            abort_act;
    logic            found;
    logic [SelW-1:0] found_ch;
    logic            tmo_hit;
    logic            store_last;
    logic [CODE_W-1:0] acc_code;

    assign abort_act = abort_i && (state_q != StIdle);
    assign tmo_hit   = (tmo_cyc_i != '0) && (tmo_cnt_q == (tmo_cyc_i - TMO_W'(1)));

`ifdef SKEW_MES_SCHED_AVG_EN
    // Errors cut the remaining repeats short so the channel stores 0 immediately.
    assign store_last = cur_err_q || (rep_q == RepW'(RepLast));
    assign acc_code   = acc_q[AccW-1 -: CODE_W];
`else
    logic unused_avg_cfg;
    assign unused_avg_cfg = (AVG_LOG2 != 0);
    assign store_last     = 1'b1;
    assign acc_code       = acc_q;
`endif

    // Lowest enabled channel at or above the pointer, resolved in one cycle.
    always_comb begin
        found    = 1'b0;
        found_ch = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (!found && mask_q[i] && (PtrW'(i) >= ptr_q)) begin
                found    = 1'b1;
                found_ch = SelW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (start_i) state_d = StSelect;
                StSelect:  state_d = found ? StSettle : StDone;
                StSettle:  if (set_cnt_q == SetW'(SETTLE_CYC - 1)) state_d = StRun;
                StRun:     if (mes_err_i || mes_rdy_i || tmo_hit) state_d = StStore;
                StStore:   state_d = StRelease;
                StRelease: state_d = again_q ? StRun : StSelect;
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        set_cnt_d   = set_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        acc_d       = acc_q;
        cur_err_d   = cur_err_q;
        cur_tmo_d   = cur_tmo_q;
        again_d     = again_q;
        res_code_d  = res_code_q;
        res_err_d   = res_err_q;
        res_tmo_d   = res_tmo_q;
        res_valid_d = res_valid_q;
`ifdef SKEW_MES_SCHED_AVG_EN
        rep_d       = rep_q;
`endif
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        run_d  = (state_d == StRun);

        if (!abort_act) begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mask_d      = ch_mask_i;
                        ptr_d       = '0;
                        res_err_d   = '0;
                        res_tmo_d   = '0;
                        res_valid_d = '0;
                    end
                end
                StSelect: begin
                    if (found) begin
                        sel_d     = found_ch;
                        set_cnt_d = '0;
                        acc_d     = '0;
                        cur_err_d = 1'b0;
                        cur_tmo_d = 1'b0;
`ifdef SKEW_MES_SCHED_AVG_EN
                        rep_d     = '0;
`endif
                    end
                end
                StSettle: begin
                    set_cnt_d = set_cnt_q + SetW'(1);
                    tmo_cnt_d = '0;
                end
                StRun: begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (mes_err_i) begin
                        cur_err_d = 1'b1;
                    end else if (mes_rdy_i) begin
`ifdef SKEW_MES_SCHED_AVG_EN
                        acc_d = acc_q + AccW'(mes_code_i);
`else
                        acc_d = mes_code_i;
`endif
                    end else if (tmo_hit) begin
                        cur_err_d = 1'b1;
                        cur_tmo_d = 1'b1;
                    end
                end
                StStore: begin
                    again_d = !store_last;
`ifdef SKEW_MES_SCHED_AVG_EN
                    if (!store_last) rep_d = rep_q + RepW'(1);
`endif
                    if (store_last) begin
                        for (int k = 0; k < int'(CH_NUM); k++) begin
                            if (sel_q == SelW'(k)) begin
                                res_code_d[k*CODE_W +: CODE_W] = cur_err_q ? '0 : acc_code;
                                res_err_d[k]   = cur_err_q;
                                res_tmo_d[k]   = cur_tmo_q;
                                res_valid_d[k] = 1'b1;
                            end
                        end
                    end
                end
                StRelease: begin
                    tmo_cnt_d = '0;
                    if (!again_q) ptr_d = PtrW'(sel_q) + PtrW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            ptr_q       <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            set_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            acc_q       <= '0;
            cur_err_q   <= 1'b0;
            cur_tmo_q   <= 1'b0;
            again_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
            res_code_q  <= '0;
            res_err_q   <= '0;
            res_tmo_q   <= '0;
            res_valid_q <= '0;
`ifdef SKEW_MES_SCHED_AVG_EN
            rep_q       <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            set_cnt_q   <= set_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            acc_q       <= acc_d;
            cur_err_q   <= cur_err_d;
            cur_tmo_q   <= cur_tmo_d;
            again_q     <= again_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            run_q       <= run_d;
            res_code_q  <= res_code_d;
            res_err_q   <= res_err_d;
            res_tmo_q   <= res_tmo_d;
            res_valid_q <= res_valid_d;
`ifdef SKEW_MES_SCHED_AVG_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ch_sel_o    = sel_q;
    assign mes_run_o   = run_q;
    assign res_code_o  = res_code_q;
    assign res_err_o   = res_err_q;
    assign res_tmo_o   = res_tmo_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_skew_mes_sched.sv
// Self-checking bench for skew_mes_sched: behavioural controller responder plus sweep-level model.
module tb_skew_mes_sched;

    localparam int CH     = 4;
    localparam int CW     = 10;
    localparam int SETTLE = 4;
    localparam int TW     = 16;
    localparam int AL     = 2;
`ifdef SKEW_MES_SCHED_AVG_EN
    localparam int REPS = 1 << AL;
`else
    localparam int REPS = 1;
`endif
    localparam int MRdy    = 0;
    localparam int MErr    = 1;
    localparam int MErrRdy = 2;
    localparam int MNever  = 3;
    localparam int Budget  = 5000;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CH-1:0] ch_mask = '0;
    logic [TW-1:0] tmo_cyc = '0;
    logic          busy, done, mes_run;
    logic [1:0]    ch_sel;
    logic          mes_rdy = 1'b0;
    logic          mes_err = 1'b0;
    logic [CW-1:0] mes_code = '0;
    logic [CH*CW-1:0] res_code;
    logic [CH-1:0] res_err, res_tmo, res_valid;

    int checks = 0;
    int failures = 0;

    // Controller behaviour per channel
    int            mode [CH];
    int            lat [CH];
    logic [CW-1:0] codes [CH][REPS];
    int            rep_idx [CH];

    // Observation record
    int pulse_ch[$];
    int pulse_len[$];
    int done_cnt = 0;
    int cur_len = 0;
    bit prev_run = 1'b0;
    int ri;

    // Expected results
    logic [CH-1:0] exp_valid, exp_err, exp_tmo;
    logic [CW-1:0] exp_code [CH];
    int            exp_cyc;
    int            exp_pch[$];
    int            exp_plen[$];

    always #5 clk = ~clk;

    skew_mes_sched #(
        .CH_NUM(CH), .CODE_W(CW), .SETTLE_CYC(SETTLE), .TMO_W(TW), .AVG_LOG2(AL)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .start_i(start), .abort_i(abort),
        .ch_mask_i(ch_mask), .tmo_cyc_i(tmo_cyc), .busy_o(busy), .done_o(done),
        .ch_sel_o(ch_sel), .mes_run_o(mes_run), .mes_rdy_i(mes_rdy), .mes_err_i(mes_err),
        .mes_code_i(mes_code), .res_code_o(res_code), .res_err_o(res_err),
        .res_tmo_o(res_tmo), .res_valid_o(res_valid)
    );

    // Responder answers after lat run-high cycles; also records run pulses and done pulses.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy !== 1'b1) for (int k = 0; k < CH; k++) rep_idx[k] = 0;
        if (mes_run === 1'b1) begin
            if (!prev_run) begin
                pulse_ch.push_back(int'(ch_sel));
                cur_len = 0;
            end
            cur_len++;
            prev_run = 1'b1;
            ri = (rep_idx[ch_sel] < REPS) ? rep_idx[ch_sel] : REPS - 1;
            if (cur_len == lat[ch_sel] && mode[ch_sel] != MNever) begin
                mes_rdy  = (mode[ch_sel] != MErr);
                mes_err  = (mode[ch_sel] == MErr) || (mode[ch_sel] == MErrRdy);
                mes_code = codes[ch_sel][ri];
            end else begin
                mes_rdy  = 1'b0;
                mes_err  = 1'b0;
                mes_code = CW'($urandom);
            end
        end else begin
            if (prev_run) begin
                pulse_len.push_back(cur_len);
                rep_idx[ch_sel]++;
            end
            prev_run = 1'b0;
            mes_rdy  = 1'b0;
            mes_err  = 1'b0;
            mes_code = CW'($urandom);
        end
    end

    task automatic model_sweep(input logic [CH-1:0] mask, input int tmo);
        int len;
        int sum;
        bit e;
        bit t;
        exp_pch.delete();
        exp_plen.delete();
        exp_valid = '0;
        exp_err   = '0;
        exp_tmo   = '0;
        exp_cyc   = 1;
        for (int ch = 0; ch < CH; ch++) begin
            if (mask[ch]) begin
                exp_cyc += 1 + SETTLE;
                e = 1'b0;
                t = 1'b0;
                sum = 0;
                for (int r = 0; r < REPS && !e; r++) begin
                    if (tmo != 0 && (mode[ch] == MNever || lat[ch] > tmo)) begin
                        len = tmo;
                        e = 1'b1;
                        t = 1'b1;
                    end else begin
                        len = lat[ch];
                        if (mode[ch] == MErr || mode[ch] == MErrRdy) e = 1'b1;
                        else sum += int'(codes[ch][r]);
                    end
                    exp_pch.push_back(ch);
                    exp_plen.push_back(len);
                    exp_cyc += len + 2;
                end
                exp_valid[ch] = 1'b1;
                exp_err[ch]   = e;
                exp_tmo[ch]   = t;
                exp_code[ch]  = e ? '0 : CW'(sum / REPS);
            end
        end
        exp_cyc += 1;
    endtask

    task automatic run_sweep(input string name, input logic [CH-1:0] mask, input int tmo,
                             output int pbase);
        int cyc;
        int dbase;
        model_sweep(mask, tmo);
        pbase = pulse_ch.size();
        dbase = done_cnt;
        @(negedge clk);
        ch_mask = mask;
        tmo_cyc = TW'(tmo);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ch_mask = CH'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy);
        end
        checks++;
        if (res_valid !== '0 || res_err !== '0 || res_tmo !== '0) begin
            failures++;
            $display("FAIL %s flags_clear: got v=%b e=%b t=%b expected 0", name, res_valid,
                     res_err, res_tmo);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < Budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 2);
        end
        checks++;
        if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_fall: got %b expected 0", name, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - dbase != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d busy=%b expected 1 busy=0", name,
                     done_cnt - dbase, busy);
        end
        checks++;
        if (res_valid !== exp_valid || res_err !== exp_err || res_tmo !== exp_tmo) begin
            failures++;
            $display("FAIL %s flags: got v=%b e=%b t=%b expected v=%b e=%b t=%b", name,
                     res_valid, res_err, res_tmo, exp_valid, exp_err, exp_tmo);
        end
        for (int ch = 0; ch < CH; ch++) begin
            checks++;
            if (res_code[ch*CW +: CW] !== exp_code[ch]) begin
                failures++;
                $display("FAIL %s code_ch%0d: got %0d expected %0d", name, ch,
                         res_code[ch*CW +: CW], exp_code[ch]);
            end
        end
        checks++;
        if (pulse_ch.size() - pbase != exp_pch.size()) begin
            failures++;
            $display("FAIL %s run_pulses: got %0d expected %0d", name,
                     pulse_ch.size() - pbase, exp_pch.size());
        end else begin
            for (int i = 0; i < exp_pch.size(); i++) begin
                checks++;
                if (pulse_ch[pbase+i] != exp_pch[i] || pulse_len[pbase+i] != exp_plen[i]) begin
                    failures++;
                    $display("FAIL %s pulse%0d: got ch%0d len%0d expected ch%0d len%0d", name, i,
                             pulse_ch[pbase+i], pulse_len[pbase+i], exp_pch[i], exp_plen[i]);
                end
            end
        end
    endtask

    task automatic set_chan(input int ch, input int m, input int l, input int code);
        mode[ch] = m;
        lat[ch]  = l;
        for (int r = 0; r < REPS; r++) codes[ch][r] = CW'(code);
    endtask

    task automatic test_reset();
        for (int ch = 0; ch < CH; ch++) begin
            set_chan(ch, MRdy, 1, 0);
            exp_code[ch] = '0;
        end
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ch_sel !== 2'd0 || mes_run !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b done=%b sel=%0d run=%b expected all 0",
                     busy, done, ch_sel, mes_run);
        end
        checks++;
        if (res_code !== '0 || res_err !== '0 || res_tmo !== '0 || res_valid !== '0) begin
            failures++;
            $display("FAIL reset_res: got code=%h e=%b t=%b v=%b expected all 0", res_code,
                     res_err, res_tmo, res_valid);
        end
    endtask

    task automatic test_mask_1011();
        int pb;
        set_chan(0, MRdy, 3, 5);
        set_chan(1, MRdy, 2, 9);
        set_chan(2, MRdy, 4, 700);
        set_chan(3, MRdy, 5, 3);
        run_sweep("mask1011", 4'b1011, 0, pb);
        checks++;
        if (res_code[CW-1:0] !== 10'd5 || res_code[2*CW-1:CW] !== 10'd9
            || res_code[4*CW-1:3*CW] !== 10'd3 || res_valid !== 4'b1011) begin
            failures++;
            $display("FAIL mask1011_literal: got c0=%0d c1=%0d c3=%0d v=%b expected 5 9 3 1011",
                     res_code[CW-1:0], res_code[2*CW-1:CW], res_code[4*CW-1:3*CW], res_valid);
        end
    endtask

    task automatic test_mask_zero();
        int pb;
        run_sweep("mask0", '0, 7, pb);
        checks++;
        if (pulse_ch.size() != pb || res_valid !== '0) begin
            failures++;
            $display("FAIL mask0_no_run: got %0d pulses v=%b expected 0 pulses v=0",
                     pulse_ch.size() - pb, res_valid);
        end
    endtask

    task automatic test_timeout();
        int pb;
        set_chan(2, MNever, 1, 0);
        set_chan(3, MRdy, 4, 123);
        run_sweep("timeout", 4'b1100, 100, pb);
        checks++;
        if (res_tmo[2] !== 1'b1 || res_err[2] !== 1'b1 || res_code[3*CW-1:2*CW] !== '0
            || pulse_len[pb] != 100 || res_valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ch2: got t=%b e=%b c=%0d len=%0d v3=%b expected 1 1 0 100 1",
                     res_tmo[2], res_err[2], res_code[3*CW-1:2*CW], pulse_len[pb], res_valid[3]);
        end
    endtask

    task automatic test_err_rdy();
        int pb;
        set_chan(0, MRdy, 2, 44);
        set_chan(1, MErrRdy, 3, 555);
        run_sweep("err_rdy", 4'b0011, 0, pb);
        checks++;
        if (res_err[1] !== 1'b1 || res_tmo[1] !== 1'b0 || res_code[2*CW-1:CW] !== '0) begin
            failures++;
            $display("FAIL err_rdy_ch1: got e=%b t=%b c=%0d expected 1 0 0", res_err[1],
                     res_tmo[1], res_code[2*CW-1:CW]);
        end
    endtask

    task automatic test_abort();
        int n;
        int dbase;
        set_chan(0, MRdy, 2, 77);
        set_chan(1, MRdy, 60, 12);
        dbase = done_cnt;
        @(negedge clk);
        ch_mask = 4'b0011;
        tmo_cyc = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mes_run === 1'b1 && ch_sel === 2'd1) && n < Budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= Budget) begin
            failures++;
            $display("FAIL abort_reach_ch1: got no ch1 run expected ch1 run");
        end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (mes_run !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_stop: got run=%b busy=%b expected 0 0", mes_run, busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != dbase || res_valid !== 4'b0001 || res_err !== '0
            || res_code[CW-1:0] !== 10'd77) begin
            failures++;
            $display("FAIL abort_results: got done=%0d v=%b e=%b c0=%0d expected 0 0001 0 77",
                     done_cnt - dbase, res_valid, res_err, res_code[CW-1:0]);
        end
        exp_code[0] = 10'd77;
    endtask

`ifdef SKEW_MES_SCHED_AVG_EN
    task automatic test_avg();
        int pb;
        mode[0] = MRdy;
        lat[0]  = 2;
        codes[0][0] = 10'd4;
        codes[0][1] = 10'd5;
        codes[0][2] = 10'd5;
        codes[0][3] = 10'd7;
        run_sweep("avg", 4'b0001, 0, pb);
        checks++;
        if (res_code[CW-1:0] !== 10'd5 || pulse_ch.size() - pb != 4) begin
            failures++;
            $display("FAIL avg_code: got %0d pulses=%0d expected 5 pulses=4", res_code[CW-1:0],
                     pulse_ch.size() - pb);
        end
    endtask
`endif

    task automatic test_random();
        int pb;
        int t;
        int r;
        logic [CH-1:0] m;
        for (int s = 0; s < 12; s++) begin
            t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
            for (int ch = 0; ch < CH; ch++) begin
                r = $urandom_range(0, 9);
                mode[ch] = (r < 6) ? MRdy : (r == 6) ? MErr : (r == 7) ? MErrRdy :
                           ((t != 0) ? MNever : MRdy);
                lat[ch] = $urandom_range(1, 8);
                for (int k = 0; k < REPS; k++) codes[ch][k] = CW'($urandom);
            end
            m = CH'($urandom);
            run_sweep("random", m, t, pb);
        end
    endtask

    task automatic test_back_to_back();
        int pb;
        set_chan(0, MRdy, 1, 1023);
        set_chan(1, MRdy, 1, 1);
        set_chan(2, MRdy, 1, 512);
        set_chan(3, MRdy, 1, 0);
        run_sweep("b2b_a", 4'b1111, 1, pb);
        set_chan(0, MErr, 1, 0);
        run_sweep("b2b_b", 4'b0001, 1, pb);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mask_1011();
        test_mask_zero();
        test_timeout();
        test_err_rdy();
        test_abort();
        test_mask_1011();
`ifdef SKEW_MES_SCHED_AVG_EN
        test_avg();
`endif
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
